// File: rtl/ghost_renderer.sv
// Bitmap ghost sprite renderer: hit test and ROM addressing, ROM read, then colour resolve.
// Three-stage pipeline; output is 3 cycles behind the scan coordinates.
module ghost_renderer #(
  parameter int NUM_GHOSTS = 4,
  parameter int SPRITE_W   = 14,
  parameter int SPRITE_H   = 14,
  parameter int COORD_W    = 9,
  parameter int ANIM_DIV   = 8,
  parameter int BLINK_DIV  = 16,
  parameter int ROM_AW     = $clog2(2*SPRITE_W*SPRITE_H)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_tick,
  input  logic [COORD_W-1:0]            sx,
  input  logic [COORD_W-1:0]            sy,
  input  logic                          de,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
  input  logic [NUM_GHOSTS*12-1:0]      ghost_color,
  input  logic [NUM_GHOSTS-1:0]         ghost_en,
  input  logic [NUM_GHOSTS-1:0]         frightened,
  input  logic                          flash,
  input  logic [NUM_GHOSTS-1:0]         eaten,
  output logic [ROM_AW-1:0]             rom_addr,
  input  logic [1:0]                    rom_data,
  output logic [3:0]                    R,
  output logic [3:0]                    G,
  output logic [3:0]                    B,
  output logic                          opaque,
  output logic                          de_out
);

  localparam int FRAME_SZ = SPRITE_W * SPRITE_H;
  localparam int ACW      = (ANIM_DIV  > 1) ? $clog2(ANIM_DIV)  : 1;
  localparam int BCW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ACW-1:0]   ANIM_LAST  = ACW'(ANIM_DIV - 1);
  localparam logic [BCW-1:0]   BLINK_LAST = BCW'(BLINK_DIV - 1);
  localparam logic [COORD_W:0] SW_EXT     = (COORD_W+1)'(SPRITE_W);
  localparam logic [COORD_W:0] SH_EXT     = (COORD_W+1)'(SPRITE_H);
  localparam logic [11:0] C_WHITE = 12'hFFF;
  localparam logic [11:0] C_BLUE  = 12'h22F;
  localparam logic [11:0] C_FACE  = 12'hFC8;

  typedef struct packed {
    logic        hit;
    logic        de;
    logic        fright;
    logic        eaten;
    logic [11:0] body;
  } side_t;

  logic [ACW-1:0] tick_cnt_d, tick_cnt_q;
  logic [BCW-1:0] blink_cnt_d, blink_cnt_q;
  logic           anim_phase_d, anim_phase_q;
  logic           blink_phase_d, blink_phase_q;

  logic [COORD_W-1:0]    gx [NUM_GHOSTS];
  logic [COORD_W-1:0]    gy [NUM_GHOSTS];
  logic [NUM_GHOSTS-1:0] hit_vec;

  logic [COORD_W-1:0] dx, dy;
  logic               sel_fright, sel_eaten;
  logic [11:0]        sel_color;
  logic [ROM_AW-1:0]  rom_addr_d, rom_addr_q;
  side_t              side_s1_d, side_s1_q;
  side_t              side_s2_d, side_s2_q;
  logic [11:0]        rgb_d, rgb_q;
  logic               opaque_d, opaque_q;
  logic               de_out_d, de_out_q;

  always_comb begin
    tick_cnt_d    = tick_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    anim_phase_d  = anim_phase_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick) begin
      if (tick_cnt_q == ANIM_LAST) begin
        tick_cnt_d   = '0;
        anim_phase_d = ~anim_phase_q;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Bounds use one extra bit so a sprite near the right/bottom edge clips instead of wrapping.
  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
      gx[i] = ghost_x[i*COORD_W +: COORD_W];
      gy[i] = ghost_y[i*COORD_W +: COORD_W];
      hit_vec[i] = de && ghost_en[i] &&
                   (sx >= gx[i]) && ({1'b0, sx} < ({1'b0, gx[i]} + SW_EXT)) &&
                   (sy >= gy[i]) && ({1'b0, sy} < ({1'b0, gy[i]} + SH_EXT));
    end
  end

  always_comb begin
    side_s1_d  = '0;
    dx         = '0;
    dy         = '0;
    sel_fright = 1'b0;
    sel_eaten  = 1'b0;
    sel_color  = '0;
    rom_addr_d = '0;
    for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
      if (hit_vec[i] && !side_s1_d.hit) begin
        side_s1_d.hit = 1'b1;
        dx         = sx - gx[i];
        dy         = sy - gy[i];
        sel_fright = frightened[i];
        sel_eaten  = eaten[i];
        sel_color  = ghost_color[i*12 +: 12];
      end
    end
    side_s1_d.de     = de;
    side_s1_d.eaten  = sel_eaten;
    side_s1_d.fright = sel_fright && !sel_eaten;
    if (sel_fright && flash && blink_phase_q) side_s1_d.body = C_WHITE;
    else if (sel_fright)                      side_s1_d.body = C_BLUE;
    else                                      side_s1_d.body = sel_color;
    if (side_s1_d.hit)
      rom_addr_d = (anim_phase_q ? ROM_AW'(FRAME_SZ) : '0) +
                   ROM_AW'(dy) * ROM_AW'(SPRITE_W) + ROM_AW'(dx);
  end

  always_comb begin
    side_s2_d = side_s1_q;
    rgb_d     = '0;
    opaque_d  = 1'b0;
    de_out_d  = side_s2_q.de;
    if (side_s2_q.hit) begin
      unique case (rom_data)
        2'd1: if (!side_s2_q.eaten) begin
          rgb_d    = side_s2_q.body;
          opaque_d = 1'b1;
        end
        2'd2: begin
          rgb_d    = side_s2_q.fright ? C_FACE : C_WHITE;
          opaque_d = 1'b1;
        end
        2'd3: begin
          rgb_d    = side_s2_q.fright ? C_FACE : C_BLUE;
          opaque_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      anim_phase_q  <= 1'b0;
      blink_phase_q <= 1'b0;
      rom_addr_q    <= '0;
      side_s1_q     <= '0;
      side_s2_q     <= '0;
      rgb_q         <= '0;
      opaque_q      <= 1'b0;
      de_out_q      <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      anim_phase_q  <= anim_phase_d;
      blink_phase_q <= blink_phase_d;
      rom_addr_q    <= rom_addr_d;
      side_s1_q     <= side_s1_d;
      side_s2_q     <= side_s2_d;
      rgb_q         <= rgb_d;
      opaque_q      <= opaque_d;
      de_out_q      <= de_out_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign R        = rgb_q[11:8];
  assign G        = rgb_q[7:4];
  assign B        = rgb_q[3:0];
  assign opaque   = opaque_q;
  assign de_out   = de_out_q;

endmodule

// File: tb/tb_ghost_renderer.sv
// Directed bench for ghost_renderer with a behavioural synchronous sprite ROM.
module tb_ghost_renderer;
  localparam int CW = 9;
  localparam int NG = 4;
  localparam int AW = 9;

  logic            clk = 1'b0;
  logic            rst, frame_tick, de, flash;
  logic [CW-1:0]   sx, sy;
  logic [NG*CW-1:0] ghost_x, ghost_y;
  logic [NG*12-1:0] ghost_color;
  logic [NG-1:0]   ghost_en, frightened, eaten;
  logic [AW-1:0]   rom_addr;
  logic [1:0]      rom_data;
  logic [3:0]      R, G, B;
  logic            opaque, de_out;

  logic [1:0] rom [0:391];
  int passed = 0;
  int total  = 0;
  logic [AW-1:0] a;
  logic [13:0]   o;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  ghost_renderer #(
    .NUM_GHOSTS(NG), .SPRITE_W(14), .SPRITE_H(14), .COORD_W(CW),
    .ANIM_DIV(2), .BLINK_DIV(1)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .sx(sx), .sy(sy), .de(de),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_color(ghost_color),
    .ghost_en(ghost_en), .frightened(frightened), .flash(flash), .eaten(eaten),
    .rom_addr(rom_addr), .rom_data(rom_data), .R(R), .G(G), .B(B),
    .opaque(opaque), .de_out(de_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one pixel for one cycle; return rom_addr after stage 0 and {RGB,opaque,de_out} after stage 2.
  task automatic pix(input int x, input int y, input logic d,
                     output logic [AW-1:0] ra, output logic [13:0] ro);
    sx = CW'(x); sy = CW'(y); de = d;
    @(posedge clk); #1;
    ra = rom_addr;
    sx = '0; sy = '0; de = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    ro = {R, G, B, opaque, de_out};
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 392; i++) rom[i] = 2'd1;
    rom[3]   = 2'd0;
    rom[75]  = 2'd2; rom[76]  = 2'd3;
    rom[271] = 2'd2; rom[272] = 2'd3;

    rst = 1'b1; frame_tick = 1'b0; de = 1'b0; flash = 1'b0;
    sx = '0; sy = '0; ghost_x = '0; ghost_y = '0; ghost_color = '0;
    ghost_en = '0; frightened = '0; eaten = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rom_addr", 32'(rom_addr), 0);
    chk("reset_outputs", 32'({R, G, B, opaque, de_out}), 0);
    rst = 1'b0;

    ghost_x[0 +: CW] = 9'd10; ghost_y[0 +: CW] = 9'd20;
    ghost_color[0 +: 12] = 12'hE11; ghost_en[0] = 1'b1;
    pix(10, 20, 1'b1, a, o);
    chk("g0_origin_addr", 32'(a), 0);
    chk("g0_origin_rgb", 32'(o), 32'({12'hE11, 1'b1, 1'b1}));
    pix(11, 21, 1'b1, a, o);
    chk("g0_inner_addr", 32'(a), 15);
    pix(24, 20, 1'b1, a, o);
    chk("g0_right_miss_addr", 32'(a), 0);
    chk("g0_right_miss_out", 32'(o), 32'({12'h000, 1'b0, 1'b1}));
    pix(10, 20, 1'b0, a, o);
    chk("de_low_out", 32'(o), 0);

    ghost_x[0 +: CW] = 9'd50; ghost_y[0 +: CW] = 9'd50;
    ghost_x[CW +: CW] = 9'd52; ghost_y[CW +: CW] = 9'd50;
    ghost_color[12 +: 12] = 12'h0F0; ghost_en[1] = 1'b1;
    pix(53, 50, 1'b1, a, o);
    chk("hole_addr", 32'(a), 3);
    chk("hole_no_show_through", 32'(o), 32'({12'h000, 1'b0, 1'b1}));
    pix(54, 50, 1'b1, a, o);
    chk("overlap_g0_wins", 32'(o), 32'({12'hE11, 1'b1, 1'b1}));
    pix(64, 50, 1'b1, a, o);
    chk("g1_only_addr", 32'(a), 12);
    chk("g1_only_rgb", 32'(o), 32'({12'h0F0, 1'b1, 1'b1}));

    ghost_en[1] = 1'b0;
    ghost_x[0 +: CW] = 9'd500; ghost_y[0 +: CW] = 9'd20;
    pix(511, 20, 1'b1, a, o);
    chk("edge_hit_addr", 32'(a), 11);
    chk("edge_hit_rgb", 32'(o), 32'({12'hE11, 1'b1, 1'b1}));
    pix(0, 20, 1'b1, a, o);
    chk("nowrap_x0", 32'(o), 32'({12'h000, 1'b0, 1'b1}));
    pix(5, 20, 1'b1, a, o);
    chk("nowrap_x5_addr", 32'(a), 0);

    ghost_x[0 +: CW] = 9'd10; ghost_y[0 +: CW] = 9'd20;
    tick(); tick();
    pix(11, 21, 1'b1, a, o);
    chk("anim_frame1_addr", 32'(a), 211);
    tick(); tick();
    pix(11, 21, 1'b1, a, o);
    chk("anim_frame0_addr", 32'(a), 15);

    frightened[0] = 1'b1; flash = 1'b1;
    pix(11, 21, 1'b1, a, o);
    chk("fright_blue", 32'(o), 32'({12'h22F, 1'b1, 1'b1}));
    tick();
    pix(11, 21, 1'b1, a, o);
    chk("fright_flash_white", 32'(o), 32'({12'hFFF, 1'b1, 1'b1}));
    tick();
    pix(11, 21, 1'b1, a, o);
    chk("fright_flash_blue_addr", 32'(a), 211);
    chk("fright_flash_blue", 32'(o), 32'({12'h22F, 1'b1, 1'b1}));
    pix(15, 25, 1'b1, a, o);
    chk("fright_eye_face", 32'(o), 32'({12'hFC8, 1'b1, 1'b1}));
    pix(16, 25, 1'b1, a, o);
    chk("fright_pupil_face", 32'(o), 32'({12'hFC8, 1'b1, 1'b1}));

    eaten[0] = 1'b1;
    pix(11, 21, 1'b1, a, o);
    chk("eaten_body_clear", 32'(o), 32'({12'h000, 1'b0, 1'b1}));
    pix(15, 25, 1'b1, a, o);
    chk("eaten_eye_white", 32'(o), 32'({12'hFFF, 1'b1, 1'b1}));
    pix(16, 25, 1'b1, a, o);
    chk("eaten_pupil", 32'(o), 32'({12'h22F, 1'b1, 1'b1}));

    eaten[0] = 1'b0;
    tick();
    pix(11, 21, 1'b1, a, o);
    chk("pre_rst_addr", 32'(a), 211);
    chk("pre_rst_white", 32'(o), 32'({12'hFFF, 1'b1, 1'b1}));

    sx = 9'd11; sy = 9'd21; de = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; frame_tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("midrst_outputs", 32'({rom_addr, R, G, B, opaque, de_out}), 0);
    end
    rst = 1'b0; frame_tick = 1'b0; de = 1'b0;
    pix(11, 21, 1'b1, a, o);
    chk("post_rst_anim0_addr", 32'(a), 15);
    chk("post_rst_blink0", 32'(o), 32'({12'h22F, 1'b1, 1'b1}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
